cell_plotter: RTL and testbench



---
 rtl/cell_plotter.sv | 184 ++++++++++++++++++
 tb/tb_cell_plotter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cell_plotter.sv
// cell_plotter
//   Rasterises one CELL x CELL board cell into the VGA adapter write port,
//   one pixel per clock, in row-major order (dx fastest).
//   select: 0 empty square, 1 cursor outline, 2 black disk, 3 white disk.
//
// Ports
//   clk        system clock
//   reset      synchronous active-high reset
//   start      draw request pulse, honoured only while idle
//   x_origin   top-left x of the cell (8 bits)
//   y_origin   top-left y of the cell (7 bits)
//   select     cell type code
//   vga_x      pixel x (origin + dx, mod 256)
//   vga_y      pixel y (origin + dy, mod 128)
//   vga_colour pixel colour
//   vga_plot   pixel write enable
//   busy       high while pixels are being emitted
//   done       one-cycle completion pulse
//
// Build option
//   CELL_PLOTTER_CLIP_EN : pixels at x>=160 or y>=120 keep their cycle slot
//                          but are not plotted. Undefined: no clipping.
module cell_plotter #(
  parameter int         CELL      = 12,
  parameter int         RADIUS    = 5,
  parameter logic [2:0] COL_BOARD = 3'b010,
  parameter logic [2:0] COL_BOX   = 3'b110,
  parameter logic [2:0] COL_BLACK = 3'b000,
  parameter logic [2:0] COL_WHITE = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_origin,
  input  logic [6:0] y_origin,
  input  logic [1:0] select,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic        [3:0]  CMAX   = 4'(CELL - 1);
  localparam logic signed [5:0]  CMAX_S = 6'(CELL - 1);
  localparam logic signed [11:0] R2     = 12'(4 * RADIUS * RADIUS);

  // Disk membership in doubled coordinates so the cell centre is integral.
  function automatic logic in_disk(input logic [3:0] cx, input logic [3:0] cy);
    logic signed [5:0]  ex, ey;
    logic signed [11:0] sx, sy;
    ex = $signed({1'b0, cx, 1'b0}) - CMAX_S;
    ey = $signed({1'b0, cy, 1'b0}) - CMAX_S;
    sx = 12'(ex);
    sy = 12'(ey);
    return (sx * sx + sy * sy) <= R2;
  endfunction

  function automatic logic [2:0] pixel_colour(input logic [1:0] s,
                                              input logic [3:0] cx,
                                              input logic [3:0] cy);
    case (s)
      2'd0:    return COL_BOARD;
      2'd1:    return (cx == 4'd0 || cx == CMAX || cy == 4'd0 || cy == CMAX)
                      ? COL_BOX : COL_BOARD;
      2'd2:    return in_disk(cx, cy) ? COL_BLACK : COL_BOARD;
      default: return in_disk(cx, cy) ? COL_WHITE : COL_BOARD;
    endcase
  endfunction

  logic [1:0] state;
  logic [7:0] xo;
  logic [6:0] yo;
  logic [1:0] sel;
  logic [3:0] dx, dy;

  logic       last_col, last_pix;
  logic [7:0] base_x_p0;
  logic [6:0] base_y_p0;
  logic [1:0] base_sel_p0;
  logic [3:0] cx_p0, cy_p0;
  logic [7:0] pix_x_p0;
  logic [6:0] pix_y_p0;
  logic [2:0] pix_colour_p0;
  logic       pix_keep_p0;

  // Stage p0: the pixel to be registered on this edge. While idle it is
  // pixel (0,0) of the incoming request, so the first pixel lands one cycle
  // after start; while drawing it is the successor of (dx,dy).
  always_comb begin
    last_col = (dx == CMAX);
    last_pix = last_col && (dy == CMAX);
    if (state == S_IDLE) begin
      base_x_p0   = x_origin;
      base_y_p0   = y_origin;
      base_sel_p0 = select;
      cx_p0       = 4'd0;
      cy_p0       = 4'd0;
    end else begin
      base_x_p0   = xo;
      base_y_p0   = yo;
      base_sel_p0 = sel;
      cx_p0       = last_col ? 4'd0 : dx + 4'd1;
      cy_p0       = last_col ? dy + 4'd1 : dy;
    end
    pix_x_p0      = base_x_p0 + {4'd0, cx_p0};
    pix_y_p0      = base_y_p0 + {3'd0, cy_p0};
    pix_colour_p0 = pixel_colour(base_sel_p0, cx_p0, cy_p0);
`ifdef CELL_PLOTTER_CLIP_EN
    pix_keep_p0   = (pix_x_p0 < 8'd160) && (pix_y_p0 < 7'd120);
`else
    pix_keep_p0   = 1'b1;
`endif
  end

  // Stage p1: registered pixel outputs and control.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      xo         <= '0;
      yo         <= '0;
      sel        <= '0;
      dx         <= '0;
      dy         <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done     <= 1'b0;
          vga_plot <= 1'b0;
          if (start) begin
            xo         <= x_origin;
            yo         <= y_origin;
            sel        <= select;
            dx         <= 4'd0;
            dy         <= 4'd0;
            vga_x      <= pix_x_p0;
            vga_y      <= pix_y_p0;
            vga_colour <= pix_colour_p0;
            vga_plot   <= pix_keep_p0;
            busy       <= 1'b1;
            state      <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (last_pix) begin
            vga_plot <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_FIN;
          end else begin
            dx         <= cx_p0;
            dy         <= cy_p0;
            vga_x      <= pix_x_p0;
            vga_y      <= pix_y_p0;
            vga_colour <= pix_colour_p0;
            vga_plot   <= pix_keep_p0;
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          vga_plot <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_plotter.sv
// tb_cell_plotter
//   Drives cell draw requests into cell_plotter and compares every output
//   cycle against a reference model that enumerates the cell's pixels by
//   index k = dy*CELL + dx and applies the colour rules arithmetically.
//   Honours CELL_PLOTTER_CLIP_EN the same way the design does.
module tb_cell_plotter;

  localparam int CELL = 12;
  localparam int NPIX = CELL * CELL;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x_origin = '0;
  logic [6:0] y_origin = '0;
  logic [1:0] select = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] got_col [NPIX];

  cell_plotter dut (
    .clk(clk), .reset(reset), .start(start),
    .x_origin(x_origin), .y_origin(y_origin), .select(select),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference colour: plain integer geometry around the cell centre.
  function automatic logic [2:0] model_colour(input int s, input int px, input int py);
    int a, b;
    a = 2 * px - (CELL - 1);
    b = 2 * py - (CELL - 1);
    if (s == 0) return 3'b010;
    if (s == 1) return (px == 0 || py == 0 || px == CELL - 1 || py == CELL - 1) ? 3'b110 : 3'b010;
    if (a * a + b * b <= 100) return (s == 2) ? 3'b000 : 3'b111;
    return 3'b010;
  endfunction

  function automatic logic model_plot(input int x, input int y);
`ifdef CELL_PLOTTER_CLIP_EN
    return (x < 160) && (y < 120);
`else
    return (x >= 0) && (y >= 0);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and checks every cycle of it. abort_at > 0 asserts
  // reset during that cycle and then checks that the draw is abandoned.
  task automatic run_draw(input int xo, input int yo, input int sel,
                          input int abort_at, output int plots, output int yellow);
    int px, py, ex, ey;
    plots  = 0;
    yellow = 0;
    x_origin = 8'(xo);
    y_origin = 7'(yo);
    select   = 2'(sel);
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= NPIX; t++) begin
      px = (t - 1) % CELL;
      py = (t - 1) / CELL;
      ex = (xo + px) % 256;
      ey = (yo + py) % 128;
      check("pix_x", vga_x, ex);
      check("pix_y", vga_y, ey);
      check("pix_col", vga_colour, model_colour(sel, px, py));
      check("pix_plot", vga_plot, model_plot(ex, ey));
      check("busy_draw", busy, 1);
      check("done_draw", done, 0);
      got_col[t - 1] = vga_colour;
      if (vga_plot) plots++;
      if (vga_plot && vga_colour == 3'b110) yellow++;
      if (t == abort_at) begin
        reset = 1'b1;
        start = 1'b0;
        step();
        reset = 1'b0;
        check("abort_plot", vga_plot, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 2 * NPIX; i++) begin
          step();
          if (done || vga_plot || busy) begin
            check("abort_quiet", {done, vga_plot, busy}, 0);
            break;
          end
        end
        return;
      end
      // Scramble the request inputs and pulse start: none of it may matter.
      x_origin = 8'($urandom);
      y_origin = 7'($urandom);
      select   = 2'($urandom);
      start    = ($urandom_range(0, 3) == 0) || (t == 49);
      step();
    end
    check("fin_done", done, 1);
    check("fin_busy", busy, 0);
    check("fin_plot", vga_plot, 0);
    start = 1'b0;
    step();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_plot", vga_plot, 0);
  endtask

  initial begin
    int plots, yellow, rx, ry, rs;

    // Reset held for three cycles.
    repeat (3) step();
    reset = 1'b0;
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_col", vga_colour, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_plot", vga_plot, 0);
    end

    // Empty cell.
    run_draw(9, 9, 0, 0, plots, yellow);
    check("empty_plots", plots, NPIX);
    check("empty_first", got_col[0], 3'b010);

    // Cursor box.
    run_draw(22, 9, 1, 0, plots, yellow);
    check("box_corner", got_col[0], 3'b110);
    check("box_33_15", got_col[6 * CELL + 11], 3'b110);
    check("box_23_10", got_col[1 * CELL + 1], 3'b010);
    check("box_yellow", yellow, 44);

    // White and black disks.
    run_draw(9, 22, 3, 0, plots, yellow);
    check("white_centre", got_col[5 * CELL + 5], 3'b111);
    check("white_dx0", got_col[5 * CELL + 0], 3'b010);
    check("white_dx1", got_col[5 * CELL + 1], 3'b111);
    run_draw(9, 22, 2, 0, plots, yellow);
    check("black_centre", got_col[5 * CELL + 5], 3'b000);
    check("black_dx1", got_col[5 * CELL + 1], 3'b000);
    check("black_dx0", got_col[5 * CELL + 0], 3'b010);

    // Reset in the middle of a draw.
    run_draw(40, 30, 3, 60, plots, yellow);

    // Screen-edge origin: clipped to a 5x5 corner when clipping is built in.
    run_draw(155, 115, 0, 0, plots, yellow);
`ifdef CELL_PLOTTER_CLIP_EN
    check("clip_plots", plots, 25);
`else
    check("clip_plots", plots, NPIX);
`endif

    // Origin near 255 wraps x.
    run_draw(250, 10, 1, 0, plots, yellow);

    // Random requests.
    for (int n = 0; n < 8; n++) begin
      rx = int'($urandom_range(0, 255));
      ry = int'($urandom_range(0, 127));
      rs = int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) step();
      run_draw(rx, ry, rs, 0, plots, yellow);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
